// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of both requester ports and the memory-side bus of the
//               two-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ack;
    logic          p0_err;
    logic [DW-1:0] p0_rdata;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ack;
    logic          p1_err;
    logic [DW-1:0] p1_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_data;
    logic          busy;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_err, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_err, p1_rdata,
        input  mem_addr, mem_wdata, mem_we, busy,
        output mem_data
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_err, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_err, p1_rdata,
        output mem_addr, mem_wdata, mem_we, busy,
        input  mem_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin two-port arbiter/sequencer for a single-port word
//               memory. Define MEM_ARB_FIXED_PRIO_EN to give port 0 fixed
//               priority on simultaneous requests.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DEPTH = 1024,
    parameter int AW    = 16,
    parameter int DW    = 32
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // One extra bit so DEPTH == 2**AW is representable and never flags.
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    state_t        r_state;
    logic          r_last_grant;
    logic          r_sel_port;
    logic          r_sel_we;
    logic [AW-1:0] r_sel_addr;
    logic [DW-1:0] r_sel_wdata;
    logic          r_range_err;
    logic          r_busy;
    logic          r_p0_ack;
    logic          r_p0_err;
    logic [DW-1:0] r_p0_rdata;
    logic          r_p1_ack;
    logic          r_p1_err;
    logic [DW-1:0] r_p1_rdata;

    logic          w_any_req;
    logic          w_grant;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_capture;

    always_comb begin
        w_any_req = bus.p0_req | bus.p1_req;
        w_grant   = bus.p1_req;
        if (bus.p0_req && bus.p1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            w_grant = 1'b0;
`else
            w_grant = ~r_last_grant;
`endif
        end
        w_we      = w_grant ? bus.p1_we    : bus.p0_we;
        w_addr    = w_grant ? bus.p1_addr  : bus.p0_addr;
        w_wdata   = w_grant ? bus.p1_wdata : bus.p0_wdata;
        w_capture = (r_range_err || r_sel_we) ? '0 : bus.mem_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_sel_port   <= 1'b0;
            r_sel_we     <= 1'b0;
            r_sel_addr   <= '0;
            r_sel_wdata  <= '0;
            r_range_err  <= 1'b0;
            r_busy       <= 1'b0;
            r_p0_ack     <= 1'b0;
            r_p0_err     <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_ack     <= 1'b0;
            r_p1_err     <= 1'b0;
            r_p1_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_sel_port   <= w_grant;
                        r_sel_we     <= w_we;
                        r_sel_addr   <= w_addr;
                        r_sel_wdata  <= w_wdata;
                        r_range_err  <= ({1'b0, w_addr} >= c_DEPTH);
                        r_last_grant <= w_grant;
                        r_busy       <= 1'b1;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_sel_port) begin
                        r_p1_ack   <= 1'b1;
                        r_p1_err   <= r_range_err;
                        r_p1_rdata <= w_capture;
                    end else begin
                        r_p0_ack   <= 1'b1;
                        r_p0_err   <= r_range_err;
                        r_p0_rdata <= w_capture;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_p0_ack <= 1'b0;
                    r_p0_err <= 1'b0;
                    r_p1_ack <= 1'b0;
                    r_p1_err <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write strobe is the only combinational output so a reset cycle can veto it.
    assign bus.mem_we    = (r_state == S_ACCESS) & r_sel_we & ~r_range_err & ~reset;
    assign bus.mem_addr  = r_sel_addr;
    assign bus.mem_wdata = r_sel_wdata;
    assign bus.busy      = r_busy;
    assign bus.p0_ack    = r_p0_ack;
    assign bus.p0_err    = r_p0_err;
    assign bus.p0_rdata  = r_p0_rdata;
    assign bus.p1_ack    = r_p1_ack;
    assign bus.p1_err    = r_p1_err;
    assign bus.p1_rdata  = r_p1_rdata;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a transaction-level
//               reference model and a behavioural word memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int DEPTH = 1024;
    localparam int AW    = 16;
    localparam int DW    = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:DEPTH-1];
    logic        ld_en   = 1'b1;
    logic [9:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (bus.mem_we && (32'(bus.mem_addr) < DEPTH))
            mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    end
    assign bus.mem_data = (32'(bus.mem_addr) < DEPTH) ? mem[bus.mem_addr[9:0]] : 32'hBAD0_BAD0;

    logic [31:0] ref_mem [0:DEPTH-1];
    bit          pend    [2];
    bit          t_we    [2];
    logic [15:0] t_addr  [2];
    logic [31:0] t_wdata [2];
    logic [31:0] exp_rdata [2];
    bit          ref_last;
    int          ack_log[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ack_of(input int p);
        return 32'(p != 0 ? bus.p1_ack : bus.p0_ack);
    endfunction
    function automatic logic [31:0] err_of(input int p);
        return 32'(p != 0 ? bus.p1_err : bus.p0_err);
    endfunction
    function automatic logic [31:0] rdata_of(input int p);
        return p != 0 ? bus.p1_rdata : bus.p0_rdata;
    endfunction

    task automatic drive_reqs();
        bus.p0_req = pend[0]; bus.p0_we = t_we[0]; bus.p0_addr = t_addr[0]; bus.p0_wdata = t_wdata[0];
        bus.p1_req = pend[1]; bus.p1_we = t_we[1]; bus.p1_addr = t_addr[1]; bus.p1_wdata = t_wdata[1];
    endtask

    task automatic set_txn(input int p, input bit we, input logic [15:0] addr, input logic [31:0] wd);
        pend[p] = 1'b1; t_we[p] = we; t_addr[p] = addr; t_wdata[p] = wd;
    endtask

    task automatic rand_txn(input int p);
        logic [15:0] a;
        if ($urandom_range(0, 9) == 0) a = 16'(1020 + $urandom_range(0, 20));
        else                           a = 16'($urandom_range(0, 63));
        set_txn(p, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    task automatic check_reset_state();
        chk("rst_busy",    32'(bus.busy),   32'd0);
        chk("rst_mem_we",  32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        for (int p = 0; p < 2; p++) begin
            chk("rst_ack",   ack_of(p),   32'd0);
            chk("rst_err",   err_of(p),   32'd0);
            chk("rst_rdata", rdata_of(p), 32'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive_reqs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ref_last = 1'b1;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        check_reset_state();
    endtask

    // Called at a falling edge while the arbiter is idle; runs one arbitration round.
    task automatic run_txn();
        int w;
        bit in_rng;
        logic [31:0] rd;
        drive_reqs();
        if (!pend[0] && !pend[1]) begin
            @(posedge clk); @(negedge clk);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_we",   32'(bus.mem_we), 32'd0);
            chk("idle_ack0", ack_of(0), 32'd0);
            chk("idle_ack1", ack_of(1), 32'd0);
            return;
        end
        if (pend[0] && pend[1]) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = ref_last ? 0 : 1;
`endif
        end else begin
            w = pend[1] ? 1 : 0;
        end
        ref_last = (w != 0);
        in_rng = (32'(t_addr[w]) < DEPTH);

        @(posedge clk); @(negedge clk);
        chk("acc_busy",  32'(bus.busy), 32'd1);
        chk("acc_addr",  32'(bus.mem_addr), 32'(t_addr[w]));
        chk("acc_wdata", bus.mem_wdata, t_wdata[w]);
        chk("acc_we",    32'(bus.mem_we), 32'(t_we[w] && in_rng));
        chk("acc_ack0",  ack_of(0), 32'd0);
        chk("acc_ack1",  ack_of(1), 32'd0);

        if (t_we[w]) begin
            rd = '0;
            if (in_rng) ref_mem[t_addr[w][9:0]] = t_wdata[w];
        end else begin
            rd = in_rng ? ref_mem[t_addr[w][9:0]] : 32'd0;
        end
        exp_rdata[w] = rd;

        @(posedge clk); @(negedge clk);
        chk("resp_busy",  32'(bus.busy), 32'd1);
        chk("resp_we",    32'(bus.mem_we), 32'd0);
        chk("resp_ack",   ack_of(w), 32'd1);
        chk("resp_noack", ack_of(1 - w), 32'd0);
        chk("resp_err",   err_of(w), 32'(!in_rng));
        chk("resp_noerr", err_of(1 - w), 32'd0);
        chk("resp_rd0",   rdata_of(0), exp_rdata[0]);
        chk("resp_rd1",   rdata_of(1), exp_rdata[1]);
        ack_log.push_back(w);
        pend[w] = 1'b0;

        @(posedge clk); @(negedge clk);
        chk("post_busy", 32'(bus.busy), 32'd0);
        chk("post_ack0", ack_of(0), 32'd0);
        chk("post_ack1", ack_of(1), 32'd0);
        chk("post_err0", err_of(0), 32'd0);
        chk("post_err1", err_of(1), 32'd0);
        chk("post_rd0",  rdata_of(0), exp_rdata[0]);
        chk("post_rd1",  rdata_of(1), exp_rdata[1]);
    endtask

    initial begin
        int exp_order [6];
        pend[0] = 1'b0; pend[1] = 1'b0;
        t_we[0] = 1'b0; t_we[1] = 1'b0;
        t_addr[0] = '0; t_addr[1] = '0;
        t_wdata[0] = '0; t_wdata[1] = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        ref_last = 1'b1;
        drive_reqs();

        // Preload memory while reset is held.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            ld_addr = 10'(i);
            ld_data = (i == 5) ? 32'hDEAD_BEEF : $urandom;
            ref_mem[i] = ld_data;
        end
        @(negedge clk);
        ld_en = 1'b0;
        reset = 1'b0;
        check_reset_state();

        // Single read of preloaded word 5.
        set_txn(0, 1'b0, 16'h0005, 32'h0);
        run_txn();
        chk("rd5_value", bus.p0_rdata, 32'hDEAD_BEEF);

        // Write from port 1 then read back from port 0.
        set_txn(1, 1'b1, 16'h0010, 32'h1234_5678);
        run_txn();
        set_txn(0, 1'b0, 16'h0010, 32'h0);
        run_txn();
        chk("wr_rd_back", bus.p0_rdata, 32'h1234_5678);

        // Both ports requesting continuously from reset.
        do_reset();
        ack_log.delete();
        rand_txn(0); t_we[0] = 1'b0;
        rand_txn(1); t_we[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            run_txn();
            for (int p = 0; p < 2; p++)
                if (!pend[p]) begin rand_txn(p); t_we[p] = 1'b0; end
        end
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        chk("order_len", 32'(ack_log.size()), 32'd6);
        for (int k = 0; k < 6 && k < ack_log.size(); k++)
            chk("ack_order", 32'(ack_log[k]), 32'(exp_order[k]));
        pend[0] = 1'b0; pend[1] = 1'b0;

        // Out-of-range write.
        set_txn(1, 1'b1, 16'h0400, 32'hFFFF_FFFF);
        run_txn();
        chk("oor_rdata", bus.p1_rdata, 32'd0);
        set_txn(0, 1'b0, 16'h0000, 32'h0);
        run_txn();
        chk("word0_keep", mem[0], ref_mem[0]);

        // Reset asserted during the access cycle of a write.
        set_txn(0, 1'b1, 16'h0020, 32'hA5A5_A5A5);
        drive_reqs();
        @(posedge clk); @(negedge clk);
        chk("pre_rst_we", 32'(bus.mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_we_gate", 32'(bus.mem_we), 32'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        pend[0] = 1'b0;
        drive_reqs();
        ref_last = 1'b1;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_ack",  32'(bus.p0_ack), 32'd0);
        chk("abort_word", mem[32], ref_mem[32]);
        @(posedge clk); @(negedge clk);
        chk("abort_ack2", 32'(bus.p0_ack), 32'd0);
        set_txn(0, 1'b0, 16'h0020, 32'h0);
        run_txn();

        // Randomized traffic against the reference model.
        for (int k = 0; k < 60; k++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(0, 2) != 0) rand_txn(p);
            run_txn();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
